// File: rtl/alu_seq.sv
// Registered N-bit ALU with start/busy/done handshake, registered status flags
// and a multi-cycle unsigned shift-add multiplier producing a double-width product.
module alu_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] result_hi,
  output logic             zero,
  output logic             carry_out,
  output logic             overflow
);

  typedef enum logic [2:0] {
    OP_AND = 3'b000,
    OP_OR  = 3'b001,
    OP_ADD = 3'b010,
    OP_XOR = 3'b011,
    OP_MUL = 3'b100,
    OP_NOR = 3'b101,
    OP_SUB = 3'b110,
    OP_SLT = 3'b111
  } alu_op_e;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_e;

  state_e  state_q, state_d;
  alu_op_e op;

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic [WIDTH-1:0] result_hi_q, result_hi_d;
  logic             zero_q, zero_d;
  logic             carry_q, carry_d;
  logic             ovf_q, ovf_d;
  logic             done_q, done_d;

  logic [WIDTH:0]   add_ext, sub_ext;
  logic             add_ovf, sub_ovf, slt;
  logic [WIDTH-1:0] alu_res;
  logic             alu_carry, alu_ovf;

  logic [WIDTH:0]   step_sum;
  logic [WIDTH-1:0] acc_step, mplier_step;
  logic             last_step;

  assign op = alu_op_e'(alu_op);

  // Single-cycle datapath
  always_comb begin
    add_ext = {1'b0, a} + {1'b0, b};
    sub_ext = {1'b0, a} + {1'b0, ~b} + (WIDTH+1)'(1);
    add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (add_ext[WIDTH-1] != a[WIDTH-1]);
    sub_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (sub_ext[WIDTH-1] != a[WIDTH-1]);
    // Difference sign corrected by overflow keeps SLT exact when a-b overflows.
    slt     = sub_ext[WIDTH-1] ^ sub_ovf;

    alu_res   = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (op)
      OP_AND: alu_res = a & b;
      OP_OR:  alu_res = a | b;
      OP_XOR: alu_res = a ^ b;
      OP_NOR: alu_res = ~(a | b);
      OP_ADD: begin
        alu_res   = add_ext[WIDTH-1:0];
        alu_carry = add_ext[WIDTH];
        alu_ovf   = add_ovf;
      end
      OP_SUB: begin
        alu_res   = sub_ext[WIDTH-1:0];
        alu_carry = sub_ext[WIDTH];
        alu_ovf   = sub_ovf;
      end
      OP_SLT: alu_res = {{(WIDTH-1){1'b0}}, slt};
      default: alu_res = '0;
    endcase
  end

  // One shift-add step: {acc, mplier} holds the partial product, shifted right per step.
  always_comb begin
    step_sum    = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_step    = step_sum[WIDTH:1];
    mplier_step = {step_sum[0], mplier_q[WIDTH-1:1]};
    last_step   = (cnt_q == WIDTH'(1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start && op == OP_MUL) state_d = S_MUL;
      S_MUL:   if (last_step) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy = (state_q == S_MUL);
  end

  always_comb begin
    cnt_d       = cnt_q;
    mcand_d     = mcand_q;
    acc_d       = acc_q;
    mplier_d    = mplier_q;
    result_d    = result_q;
    result_hi_d = result_hi_q;
    zero_d      = zero_q;
    carry_d     = carry_q;
    ovf_d       = ovf_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op == OP_MUL) begin
            mcand_d  = a;
            mplier_d = b;
            acc_d    = '0;
            cnt_d    = WIDTH'(WIDTH);
          end else begin
            result_d    = alu_res;
            result_hi_d = '0;
            zero_d      = (alu_res == '0);
            carry_d     = alu_carry;
            ovf_d       = alu_ovf;
            done_d      = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d    = acc_step;
        mplier_d = mplier_step;
        cnt_d    = cnt_q - WIDTH'(1);
        if (last_step) begin
          result_d    = mplier_step;
          result_hi_d = acc_step;
          zero_d      = (mplier_step == '0) && (acc_step == '0);
          carry_d     = 1'b0;
          ovf_d       = 1'b0;
          done_d      = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      mcand_q     <= '0;
      acc_q       <= '0;
      mplier_q    <= '0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      carry_q     <= 1'b0;
      ovf_q       <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      mcand_q     <= mcand_d;
      acc_q       <= acc_d;
      mplier_q    <= mplier_d;
      result_q    <= result_d;
      result_hi_q <= result_hi_d;
      zero_q      <= zero_d;
      carry_q     <= carry_d;
      ovf_q       <= ovf_d;
      done_q      <= done_d;
    end
  end

  assign done      = done_q;
  assign result    = result_q;
  assign result_hi = result_hi_q;
  assign zero      = zero_q;
  assign carry_out = carry_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: 8-bit and 32-bit instances driven with directed
// and random operations, compared against an arithmetic reference model.
module tb_alu_seq;

  logic clk = 1'b0;
  logic rst;

  logic        start8;
  logic [2:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, zero8, c8, v8;
  logic [7:0]  res8, hi8;

  logic        start32;
  logic [2:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, zero32, c32, v32;
  logic [31:0] res32, hi32;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .alu_op(op8), .a(a8), .b(b8),
    .busy(busy8), .done(done8), .result(res8), .result_hi(hi8),
    .zero(zero8), .carry_out(c8), .overflow(v8)
  );

  alu_seq #(.WIDTH(32)) u_dut32 (
    .clk(clk), .rst(rst), .start(start32), .alu_op(op32), .a(a32), .b(b32),
    .busy(busy32), .done(done32), .result(res32), .result_hi(hi32),
    .zero(zero32), .carry_out(c32), .overflow(v32)
  );

  typedef struct {
    longint unsigned res;
    longint unsigned hi;
    bit              z;
    bit              c;
    bit              v;
  } exp_t;

  typedef struct {
    logic [63:0] res;
    logic [63:0] hi;
    logic        busy;
    logic        done;
    logic        z;
    logic        c;
    logic        v;
  } obs_t;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  exp_t        last_e[2];
  exp_t        zero_e = '{0, 0, 0, 0, 0};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input int w, input logic [2:0] op,
                                 input longint unsigned a, input longint unsigned b);
    exp_t            e;
    longint unsigned mask, p;
    longint          sa, sb, smax, smin, r;
    mask = (64'd1 << w) - 1;
    sa   = a[w-1] ? longint'(a) - (longint'(1) << w) : longint'(a);
    sb   = b[w-1] ? longint'(b) - (longint'(1) << w) : longint'(b);
    smax = (longint'(1) << (w-1)) - 1;
    smin = -(longint'(1) << (w-1));
    e    = '{0, 0, 0, 0, 0};
    case (op)
      3'b000: e.res = a & b;
      3'b001: e.res = a | b;
      3'b011: e.res = a ^ b;
      3'b101: e.res = ~(a | b) & mask;
      3'b010: begin
        r     = sa + sb;
        e.res = (a + b) & mask;
        e.c   = ((a + b) >> w) != 0;
        e.v   = (r > smax) || (r < smin);
      end
      3'b110: begin
        r     = sa - sb;
        e.res = (a - b) & mask;
        e.c   = (a >= b);
        e.v   = (r > smax) || (r < smin);
      end
      3'b111: e.res = (sa < sb) ? 1 : 0;
      default: begin
        p     = a * b;
        e.res = p & mask;
        e.hi  = p >> w;
      end
    endcase
    e.z = (e.res == 0) && (e.hi == 0);
    return e;
  endfunction

  function automatic obs_t sample(input int w);
    obs_t o;
    if (w == 8) begin
      o = '{64'(res8), 64'(hi8), busy8, done8, zero8, c8, v8};
    end else begin
      o = '{64'(res32), 64'(hi32), busy32, done32, zero32, c32, v32};
    end
    return o;
  endfunction

  task automatic drive(input int w, input bit s, input logic [2:0] op,
                       input longint unsigned a, input longint unsigned b);
    if (w == 8) begin
      start8 = s; op8 = op; a8 = a[7:0]; b8 = b[7:0];
    end else begin
      start32 = s; op32 = op; a32 = a[31:0]; b32 = b[31:0];
    end
  endtask

  function automatic longint unsigned rand_opnd(input int w);
    longint unsigned mask;
    mask = (64'd1 << w) - 1;
    case ($urandom_range(0, 5))
      0: return 0;
      1: return mask;
      2: return 64'd1 << (w-1);
      3: return mask >> 1;
      default: return longint'($urandom) & mask;
    endcase
  endfunction

  task automatic check_out(input int w, input string pfx, input exp_t e);
    obs_t o;
    o = sample(w);
    check({pfx, "_res"},  o.res, e.res);
    check({pfx, "_hi"},   o.hi,  e.hi);
    check({pfx, "_zero"}, o.z,   e.z);
    check({pfx, "_cout"}, o.c,   e.c);
    check({pfx, "_ovf"},  o.v,   e.v);
  endtask

  task automatic check_reset(input int w, input string pfx);
    obs_t o;
    o = sample(w);
    check({pfx, "_busy"}, o.busy, 0);
    check({pfx, "_done"}, o.done, 0);
    check_out(w, pfx, zero_e);
  endtask

  task automatic single(input int w, input logic [2:0] op,
                        input longint unsigned a, input longint unsigned b);
    exp_t e;
    obs_t o;
    @(negedge clk);
    drive(w, 1, op, a, b);
    e = model(w, op, a, b);
    @(posedge clk);
    #1;
    o = sample(w);
    check("op_done", o.done, 1);
    check("op_busy", o.busy, 0);
    check_out(w, "op", e);
    last_e[w == 32] = e;
  endtask

  task automatic idle(input int w);
    obs_t o;
    @(negedge clk);
    drive(w, 0, 3'b000, 0, 0);
    @(posedge clk);
    #1;
    o = sample(w);
    check("idle_done", o.done, 0);
    check("idle_busy", o.busy, 0);
    check_out(w, "idle_hold", last_e[w == 32]);
  endtask

  task automatic mul(input int w, input longint unsigned a, input longint unsigned b,
                     input bit probe);
    exp_t            e;
    obs_t            o;
    longint unsigned pa, pb;
    int              idx;
    idx = (w == 32) ? 1 : 0;
    @(negedge clk);
    drive(w, 1, 3'b100, a, b);
    e = model(w, 3'b100, a, b);
    @(posedge clk);
    #1;
    o = sample(w);
    check("mul_busy_start", o.busy, 1);
    check("mul_done_start", o.done, 0);
    check("mul_hold_start", o.res, last_e[idx].res);
    @(negedge clk);
    pa = rand_opnd(w);
    pb = rand_opnd(w);
    if (probe) drive(w, 1, 3'b000, pa, pb);
    else       drive(w, 0, 3'b000, 0, 0);
    for (int i = 1; i <= w; i++) begin
      @(posedge clk);
      #1;
      o = sample(w);
      if (i < w) begin
        check("mul_busy", o.busy, 1);
        check("mul_done_early", o.done, 0);
        check("mul_hold", o.res, last_e[idx].res);
      end else begin
        check("mul_done", o.done, 1);
        check("mul_busy_end", o.busy, 0);
        check_out(w, "mul", e);
      end
    end
    last_e[idx] = e;
    if (probe) begin
      // start held through busy: the earliest acceptance is the edge after done
      e = model(w, 3'b000, pa, pb);
      @(posedge clk);
      #1;
      o = sample(w);
      check("post_mul_done", o.done, 1);
      check_out(w, "post_mul", e);
      last_e[idx] = e;
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0]      bb_op[4];
    logic [7:0]      bb_exp[4];
    logic [2:0]      op;
    longint unsigned ra, rb;
    int unsigned     n_done;

    bb_op  = '{3'b000, 3'b001, 3'b011, 3'b101};
    bb_exp = '{8'h30, 8'hFC, 8'hCC, 8'h03};
    last_e[0] = zero_e;
    last_e[1] = zero_e;

    rst = 1'b1;
    drive(8, 0, 3'b000, 0, 0);
    drive(32, 0, 3'b000, 0, 0);
    #1;
    check_reset(8, "rst_init8");
    check_reset(32, "rst_init32");
    @(negedge clk);
    rst = 1'b0;

    single(8, 3'b010, 8'h7F, 8'h01);
    check("tp_add_ovf_res", res8, 8'h80);
    check("tp_add_ovf_v", v8, 1);
    single(8, 3'b010, 8'hFF, 8'h01);
    check("tp_add_wrap_z", zero8, 1);
    check("tp_add_wrap_c", c8, 1);
    single(8, 3'b110, 8'h05, 8'h07);
    check("tp_sub_res", res8, 8'hFE);
    check("tp_sub_c", c8, 0);
    single(8, 3'b111, 8'h80, 8'h7F);
    check("tp_slt_ovf", res8, 8'h01);
    single(8, 3'b111, 8'h7F, 8'h80);
    check("tp_slt_neg", res8, 8'h00);
    idle(8);

    mul(8, 8'hFF, 8'hFF, 1);
    check("tp_mul8_hi_seen", last_e[0].res, 64'(res8));
    idle(8);
    mul(8, 8'hFF, 8'hFF, 0);
    check("tp_mul8_res", res8, 8'h01);
    check("tp_mul8_hi", hi8, 8'hFE);

    for (int i = 0; i < 4; i++) begin
      single(8, bb_op[i], 8'hF0, 8'h3C);
      check("b2b_res", res8, bb_exp[i]);
    end
    idle(8);

    // asynchronous reset between edges clears outputs without a clock
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_reset(8, "rst_async8");
    @(negedge clk);
    rst = 1'b0;
    last_e[0] = zero_e;
    last_e[1] = zero_e;

    @(negedge clk);
    drive(32, 1, 3'b100, 32'hDEADBEEF, 32'h00012345);
    @(posedge clk);
    @(negedge clk);
    drive(32, 0, 3'b000, 0, 0);
    repeat (9) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_reset(32, "rst_mid_mul");
    @(negedge clk);
    rst = 1'b0;
    n_done = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (done32 === 1'b1) n_done++;
    end
    check("abort_no_done", n_done, 0);
    check("abort_res", res32, 0);
    check("abort_busy", busy32, 0);
    last_e[0] = zero_e;
    last_e[1] = zero_e;

    mul(32, 12345, 6789, 0);
    check("tp_mul32_res", res32, 32'd83810205);

    for (int it = 0; it < 250; it++) begin
      op = 3'($urandom_range(0, 7));
      ra = rand_opnd(8);
      rb = rand_opnd(8);
      if (op == 3'b100) mul(8, ra, rb, 1'($urandom_range(0, 1)));
      else              single(8, op, ra, rb);
      if ($urandom_range(0, 3) == 0) idle(8);
    end
    idle(8);

    for (int it = 0; it < 40; it++) begin
      op = 3'($urandom_range(0, 7));
      ra = rand_opnd(32);
      rb = rand_opnd(32);
      if (op == 3'b100) mul(32, ra, rb, 1'($urandom_range(0, 1)));
      else              single(32, op, ra, rb);
    end
    idle(32);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_seq.md
# alu_seq

Registered, parametrised N-bit ALU that succeeds the 1-bit bit-sliced ALU cell in the datapath. It adds a start/busy/done handshake, registered status flags (zero, carry, overflow), and a multi-cycle unsigned shift-add multiplier with a double-width product. It sits between the register-file read stage and write-back. The control unit issues one operation at a time and waits for `done`.

## Interface
- `WIDTH`, default 32: operand/result width, ≥2.
- `clk` input 1: single clock, all state updates on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: operation request, sampled on rising edge when not busy.
- `alu_op` input 3: operation select, sampled with `start`.
- `a` input WIDTH: operand A, sampled with `start`.
- `b` input WIDTH: operand B, sampled with `start`.
- `busy` output 1: multiplier in progress; new `start` ignored.
- `done` output 1: one-cycle pulse; result/flags updated this cycle.
- `result` output WIDTH: result (low product half for MUL).
- `result_hi` output WIDTH: high product half for MUL, 0 otherwise.
- `zero` output 1: result (and `result_hi` for MUL) all zero.
- `carry_out` output 1: carry out of the MSB for ADD/SUB, else 0.
- `overflow` output 1: signed overflow for ADD/SUB, else 0.

## Operation
- Encoding of `alu_op`:
  - 000 AND
  - 001 OR
  - 010 ADD
  - 011 XOR
  - 100 MUL (unsigned, multi-cycle)
  - 101 NOR
  - 110 SUB
  - 111 SLT (signed)
- SUB is computed as a + ~b + 1. `carry_out`=1 means no borrow.
- ADD/SUB `overflow` = operand signs agree (after b inversion for SUB) and the result sign differs.
- SLT result = {0…0, a<b signed}. It is correct even when a−b overflows. `carry_out`=`overflow`=0.
- Logic ops and SLT: `carry_out`=`overflow`=0, `result_hi`=0.
- MUL: 2·WIDTH-bit unsigned product; `result`=low half, `result_hi`=high half. `carry_out`=`overflow`=0. `zero` covers both halves.
- States:
  - IDLE: `start`=1 with a single-cycle op loads outputs and stays in IDLE. `start`=1 with MUL latches operands and goes to MUL.
  - MUL: one shift-add step per cycle. An internal WIDTH-bit counter counts down from WIDTH. When the last step completes, outputs are written and the state returns to IDLE.
- Outputs hold their last values until the next completion. A `start` that is ignored does not alter them.
- `start` while `busy`=1 is ignored (not queued).
- Reset value of every output is 0: `busy`, `done`, `result`, `result_hi`, `zero`, `carry_out`, `overflow`. State resets to IDLE and the counter to 0.
- Reset asserted mid-MUL aborts the operation: no `done`, outputs return to 0.

## Timing
- Single-cycle ops: `start` sampled at edge k → `result`/flags valid and `done`=1 from edge k until edge k+1. Latency is 1 cycle.
- Back-to-back single-cycle ops: `start` may stay high every cycle, giving one result and one `done` per cycle (`done` stays high continuously).
- MUL: `start` sampled at edge k → `busy`=1 from edge k to edge k+WIDTH. Result, flags and `done`=1 appear at edge k+WIDTH, with `busy`=0 in the same cycle. Latency is WIDTH cycles.
- A new `start` is accepted at edge k+WIDTH+1 at the earliest, i.e. the cycle in which `done` is high.
- `done` is never high for more than one cycle per accepted operation.

## Test plan
- Reset: assert `rst` asynchronously mid-cycle → all outputs 0 immediately, `busy`=0.
- WIDTH=8 ADD:
  - a=0x7F, b=0x01 → `result`=0x80, `overflow`=1, `carry_out`=0, `done` one cycle after start.
  - a=0xFF, b=0x01 → `result`=0x00, `zero`=1, `carry_out`=1.
- WIDTH=8 SUB/SLT:
  - SUB a=0x05, b=0x07 → 0xFE, `carry_out`=0.
  - SLT a=0x80, b=0x7F → 0x01 (overflow case).
  - SLT a=0x7F, b=0x80 → 0x00.
- WIDTH=8 MUL: a=0xFF, b=0xFF → `result`=0x01, `result_hi`=0xFE. `busy` is high for 8 cycles and `done` rises exactly 8 cycles after start. A `start` (op=AND) issued during `busy` is ignored.
- Back-to-back single-cycle ops: AND 0xF0&0x3C, OR, XOR, NOR on consecutive cycles → 0x30, 0xFC, 0xCC, 0x03 on consecutive cycles, `done` continuously high.
- Reset mid-MUL (WIDTH=32, reset at cycle 10 of 32) → no `done`. A following MUL 12345×6789 completes correctly with `result`=83810205.
